// File: rtl/dodge_game_core.sv
// Game-logic core for the dodgeball game: falling objects, one player on a
// fixed row, collision detection, saturating dodge score and an
// IDLE/PLAY/OVER state machine. Everything runs on CLK_in and advances one
// game step per `tick` strobe; outputs are grid coordinates for the renderer.
module dodge_game_core #(
    parameter int GRID_W       = 16,
    parameter int GRID_H       = 12,
    parameter int N_OBJ        = 3,
    parameter int PLAYER_ROW   = 10,
    parameter int PLAYER_START = 8,
    parameter int CYCLE_LEN    = 20,
    parameter int STAGGER      = 4,
    parameter int SCORE_W      = 8,
    localparam int XW          = $clog2(GRID_W),
    localparam int YW          = $clog2(GRID_H),
    localparam int JW          = $clog2(CYCLE_LEN)
) (
    input  logic                  CLK_in,
    input  logic                  RST_BTN,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  left,
    input  logic                  right,
    output logic [1:0]            state,
    output logic [XW-1:0]         player_x,
    output logic [N_OBJ*XW-1:0]   obj_x,
    output logic [N_OBJ*YW-1:0]   obj_y,
    output logic [N_OBJ-1:0]      obj_active,
    output logic [SCORE_W-1:0]    score,
    output logic                  hit,
    output logic                  dodge
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // 16-bit Galois LFSR, taps 16/14/13/11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0]) begin
            lfsr_step = (v >> 1) ^ 16'hB400;
        end else begin
            lfsr_step = v >> 1;
        end
    endfunction

    // Fold an XW-bit random value into the legal column range
    function automatic logic [XW-1:0] col_fold(input logic [XW-1:0] c);
        if ({1'b0, c} >= (XW+1)'(GRID_W)) begin
            col_fold = c - XW'(GRID_W);
        end else begin
            col_fold = c;
        end
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [XW-1:0]          player_x_r, player_x_nxt_s;
    logic [N_OBJ*XW-1:0]    obj_x_r, obj_x_nxt_s;
    logic [N_OBJ*YW-1:0]    obj_y_r, obj_y_nxt_s;
    logic [N_OBJ-1:0]       obj_active_r, obj_active_nxt_s;
    logic [SCORE_W-1:0]     score_r, score_nxt_s;
    logic [JW-1:0]          j_r, j_nxt_s;
    logic                   hit_r, hit_nxt_s;
    logic                   dodge_r, dodge_nxt_s;
    logic                   start_q_r;
    logic [15:0]            lfsr_r;

    logic                   start_ev_s;
    logic                   collide_s;
    logic [XW-1:0]          col_s;
    logic [3:0]             dodged_cnt_s;
    logic [SCORE_W+3:0]     score_sum_s;

    // Next-state and next-datapath computation for one game step
    always_comb begin
        start_ev_s       = start & ~start_q_r;
        col_s            = col_fold(lfsr_r[XW-1:0]);
        collide_s        = 1'b0;
        dodged_cnt_s     = 4'd0;
        score_sum_s      = {(SCORE_W+4){1'b0}};
        state_nxt_s      = state_r;
        player_x_nxt_s   = player_x_r;
        obj_x_nxt_s      = obj_x_r;
        obj_y_nxt_s      = obj_y_r;
        obj_active_nxt_s = obj_active_r;
        score_nxt_s      = score_r;
        j_nxt_s          = j_r;
        hit_nxt_s        = 1'b0;
        dodge_nxt_s      = 1'b0;

        // Collision uses the pre-step positions
        for (int k = 0; k < N_OBJ; k++) begin
            collide_s = collide_s |
                        (obj_active_r[k] &&
                         (obj_x_r[k*XW +: XW] == player_x_r) &&
                         (obj_y_r[k*YW +: YW] == YW'(PLAYER_ROW)));
        end

        case (state_r)
            ST_IDLE: begin
                j_nxt_s          = {JW{1'b0}};
                obj_x_nxt_s      = {(N_OBJ*XW){1'b0}};
                obj_y_nxt_s      = {(N_OBJ*YW){1'b0}};
                obj_active_nxt_s = {N_OBJ{1'b0}};
                score_nxt_s      = {SCORE_W{1'b0}};
                player_x_nxt_s   = XW'(PLAYER_START);
                if (start_ev_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (collide_s) begin
                    // Freeze the board; only the LFSR and start_q keep moving
                    state_nxt_s = ST_OVER;
                    hit_nxt_s   = 1'b1;
                end else begin
                    if (left && !right && (player_x_r != {XW{1'b0}})) begin
                        player_x_nxt_s = player_x_r - XW'(1);
                    end else if (right && !left && (player_x_r < XW'(GRID_W-1))) begin
                        player_x_nxt_s = player_x_r + XW'(1);
                    end else begin
                        player_x_nxt_s = player_x_r;
                    end

                    // Active objects fall or leave; inactive ones may launch in their slot
                    for (int k = 0; k < N_OBJ; k++) begin
                        if (obj_active_r[k]) begin
                            if (obj_y_r[k*YW +: YW] == YW'(GRID_H-1)) begin
                                obj_active_nxt_s[k] = 1'b0;
                                dodged_cnt_s        = dodged_cnt_s + 4'd1;
                            end else begin
                                obj_y_nxt_s[k*YW +: YW] = obj_y_r[k*YW +: YW] + YW'(1);
                            end
                        end else begin
                            if (j_r == JW'(k*STAGGER)) begin
                                obj_active_nxt_s[k]     = 1'b1;
                                obj_y_nxt_s[k*YW +: YW] = {YW{1'b0}};
                                obj_x_nxt_s[k*XW +: XW] = col_s;
                            end else begin
                                obj_active_nxt_s[k] = 1'b0;
                            end
                        end
                    end

                    score_sum_s = {4'd0, score_r} + {{SCORE_W{1'b0}}, dodged_cnt_s};
                    if (score_sum_s[SCORE_W+3:SCORE_W] != 4'd0) begin
                        score_nxt_s = {SCORE_W{1'b1}};
                    end else begin
                        score_nxt_s = score_sum_s[SCORE_W-1:0];
                    end
                    dodge_nxt_s = (dodged_cnt_s != 4'd0);

                    if (j_r == JW'(CYCLE_LEN-1)) begin
                        j_nxt_s = {JW{1'b0}};
                    end else begin
                        j_nxt_s = j_r + JW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_ev_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Game state register, advanced only on tick
    always_ff @(posedge CLK_in) begin
        if (RST_BTN) begin
            state_r <= ST_IDLE;
        end else if (tick) begin
            state_r <= state_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Datapath registers; hit/dodge are pulses that drop in non-tick cycles
    always_ff @(posedge CLK_in) begin
        if (RST_BTN) begin
            player_x_r   <= XW'(PLAYER_START);
            obj_x_r      <= {(N_OBJ*XW){1'b0}};
            obj_y_r      <= {(N_OBJ*YW){1'b0}};
            obj_active_r <= {N_OBJ{1'b0}};
            score_r      <= {SCORE_W{1'b0}};
            j_r          <= {JW{1'b0}};
            hit_r        <= 1'b0;
            dodge_r      <= 1'b0;
            start_q_r    <= 1'b0;
            lfsr_r       <= 16'hACE1;
        end else if (tick) begin
            player_x_r   <= player_x_nxt_s;
            obj_x_r      <= obj_x_nxt_s;
            obj_y_r      <= obj_y_nxt_s;
            obj_active_r <= obj_active_nxt_s;
            score_r      <= score_nxt_s;
            j_r          <= j_nxt_s;
            hit_r        <= hit_nxt_s;
            dodge_r      <= dodge_nxt_s;
            start_q_r    <= start;
            lfsr_r       <= lfsr_step(lfsr_r);
        end else begin
            hit_r        <= 1'b0;
            dodge_r      <= 1'b0;
        end
    end

    assign state      = state_r;
    assign player_x   = player_x_r;
    assign obj_x      = obj_x_r;
    assign obj_y      = obj_y_r;
    assign obj_active = obj_active_r;
    assign score      = score_r;
    assign hit        = hit_r;
    assign dodge      = dodge_r;

endmodule
